// File: rtl/counter_modn_updown.sv
// Cascaded modulo-N up/down counter: DIGITS stages of WIDTH bits, each counting 0..MODULUS-1,
// with synchronous parallel load (out-of-range digits forced to 0 and flagged).
module counter_modn_updown #(
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4,
    parameter int DIGITS  = 2
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic                      enable_in,
    input  logic                      up_down_in,
    input  logic                      load_in,
    input  logic [DIGITS*WIDTH-1:0]   load_value_in,
    output logic [DIGITS*WIDTH-1:0]   count_out,
    output logic                      terminal_count_out,
    output logic                      overflow_out,
    output logic                      load_error_out
);

    localparam logic [WIDTH-1:0] MAX_DIGIT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    // One extra bit so MODULUS == 2**WIDTH is representable for the range check.
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);

    logic [DIGITS*WIDTH-1:0] count_q;
    logic [DIGITS*WIDTH-1:0] count_step;
    logic [DIGITS*WIDTH-1:0] count_load;
    logic [DIGITS:0]         ripple;
    logic [WIDTH-1:0]        cur_digit;
    logic [WIDTH-1:0]        load_field;
    logic                    load_bad;
    logic                    overflow_q;
    logic                    load_error_q;

    // ripple[k] is high when every lower digit sits at its wrap value for the
    // current direction, so digit k moves on an enabled edge.
    always_comb begin
        count_step = count_q;
        count_load = '0;
        load_bad   = 1'b0;
        ripple     = '0;
        ripple[0]  = 1'b1;
        cur_digit  = '0;
        load_field = '0;
        for (int k = 0; k < DIGITS; k++) begin
            cur_digit = count_q[k*WIDTH +: WIDTH];
            if (up_down_in) begin
                ripple[k+1] = ripple[k] & (cur_digit == MAX_DIGIT);
                if (ripple[k])
                    count_step[k*WIDTH +: WIDTH] = (cur_digit == MAX_DIGIT) ? '0 : cur_digit + ONE;
            end else begin
                ripple[k+1] = ripple[k] & (cur_digit == '0);
                if (ripple[k])
                    count_step[k*WIDTH +: WIDTH] = (cur_digit == '0) ? MAX_DIGIT : cur_digit - ONE;
            end

            load_field = load_value_in[k*WIDTH +: WIDTH];
            if ({1'b0, load_field} < MOD_EXT)
                count_load[k*WIDTH +: WIDTH] = load_field;
            else
                load_bad = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            count_q      <= '0;
            overflow_q   <= 1'b0;
            load_error_q <= 1'b0;
        end else if (load_in) begin
            count_q      <= count_load;
            overflow_q   <= 1'b0;
            load_error_q <= load_bad;
        end else begin
            load_error_q <= 1'b0;
            overflow_q   <= enable_in & ripple[DIGITS];
            if (enable_in)
                count_q <= count_step;
        end
    end

    assign count_out          = count_q;
    assign terminal_count_out = ripple[DIGITS];
    assign overflow_out       = overflow_q;
    assign load_error_out     = load_error_q;

endmodule

// File: tb/tb_counter_modn_updown.sv
// Bench for the two-digit decimal configuration: integer reference model, constant vector
// table for load/wrap corners, directed sequences and random traffic.
module tb_counter_modn_updown;

    logic       clk_in = 1'b0;
    logic       reset_in = 1'b0;
    logic       enable_in = 1'b0;
    logic       up_down_in = 1'b1;
    logic       load_in = 1'b0;
    logic [7:0] load_value_in = '0;
    logic [7:0] count_out;
    logic       terminal_count_out;
    logic       overflow_out;
    logic       load_error_out;

    counter_modn_updown #(.MODULUS(10), .WIDTH(4), .DIGITS(2)) dut (
        .clk_in             (clk_in),
        .reset_in           (reset_in),
        .enable_in          (enable_in),
        .up_down_in         (up_down_in),
        .load_in            (load_in),
        .load_value_in      (load_value_in),
        .count_out          (count_out),
        .terminal_count_out (terminal_count_out),
        .overflow_out       (overflow_out),
        .load_error_out     (load_error_out)
    );

    // clock
    always #5 clk_in = ~clk_in;

    // scoreboard: {count, overflow, load_error}
    logic [9:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // reference model: counter value as a plain integer 0..99
    int   m_val   = 0;
    logic m_valid = 1'b0;

    typedef struct {
        logic       rst, ld, en, ud;
        logic [7:0] lv;
        logic [7:0] exp_count;
        logic       exp_ovf, exp_lerr;
    } vec_t;
    vec_t vecs[12];

    task automatic step(input logic rst, input logic ld, input logic en, input logic ud,
                        input logic [7:0] lv, input logic has_exp, input logic [9:0] exp_v,
                        input string tag);
        int         nv;
        logic       tc_e, ovf_e, lerr_e;
        logic [3:0] lo, hi;
        logic [9:0] want, got;
        @(negedge clk_in);
        reset_in = rst; load_in = ld; enable_in = en; up_down_in = ud; load_value_in = lv;
        #1;
        tc_e = ud ? (m_val == 99) : (m_val == 0);
        if (m_valid) begin
            n_cmp++;
            if (terminal_count_out !== tc_e) begin
                n_err++;
                $display("FAIL %s tc: got %b want %b (model %0d)", tag, terminal_count_out, tc_e, m_val);
            end
        end
        ovf_e = 1'b0; lerr_e = 1'b0; nv = m_val;
        if (rst) begin
            nv = 0;
        end else if (ld) begin
            lo = lv[3:0]; hi = lv[7:4];
            lerr_e = (lo > 9) || (hi > 9);
            if (lo > 9) lo = 0;
            if (hi > 9) hi = 0;
            nv = int'(hi) * 10 + int'(lo);
        end else if (en) begin
            ovf_e = tc_e;
            nv = ud ? (m_val + 1) % 100 : (m_val + 99) % 100;
        end
        m_val = nv; m_valid = 1'b1;
        exp_q.push_back(has_exp ? exp_v : {4'(nv / 10), 4'(nv % 10), ovf_e, lerr_e});
        @(posedge clk_in);
        #1;
        got = {count_out, overflow_out, load_error_out};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_err++;
                $display("FAIL %s: count/ovf/lerr got %h/%b/%b want %h/%b/%b",
                         tag, got[9:2], got[1], got[0], want[9:2], want[1], want[0]);
            end
        end
    endtask

    task automatic run(input logic rst, input logic ld, input logic en, input logic ud,
                       input logic [7:0] lv, input string tag);
        step(rst, ld, en, ud, lv, 1'b0, '0, tag);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h37, 8'h37, 1'b0, 1'b0}; // load beats enable
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h38, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h05, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h05, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h9A, 8'h90, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h99, 8'h99, 1'b0, 1'b0}; // load at tc: no overflow
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h00, 1'b0, 1'b0}; // reset beats load

        // reset, then reset held with down direction (tc high at count 0)
        run(1, 0, 0, 1, 8'h00, "reset");
        run(1, 0, 1, 0, 8'h00, "reset_tc_down");

        // full up cycle 00..99..00
        run(1, 0, 0, 1, 8'h00, "reset_up");
        for (int i = 0; i < 101; i++) run(0, 0, 1, 1, 8'h00, "up_cycle");

        // down from 00 through 99 and several borrows
        run(1, 0, 0, 0, 8'h00, "reset_down");
        for (int i = 0; i < 25; i++) run(0, 0, 1, 0, 8'h00, "down_cycle");

        // constant vector table
        for (int i = 0; i < 12; i++)
            step(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].ud, vecs[i].lv, 1'b1,
                 {vecs[i].exp_count, vecs[i].exp_ovf, vecs[i].exp_lerr}, $sformatf("vec%0d", i));

        // count to 42, hold, reset while enabled, resume
        run(1, 0, 0, 1, 8'h00, "reset_hold");
        for (int i = 0; i < 42; i++) run(0, 0, 1, 1, 8'h00, "to_42");
        for (int i = 0; i < 5; i++) run(0, 0, 0, 1, 8'h00, "hold_42");
        run(1, 0, 1, 1, 8'h00, "reset_mid");
        step(0, 0, 1, 1, 8'h00, 1'b1, {8'h01, 1'b0, 1'b0}, "resume_01");

        // direction flips at 59
        step(0, 1, 0, 1, 8'h59, 1'b1, {8'h59, 1'b0, 1'b0}, "load_59");
        step(0, 0, 1, 0, 8'h00, 1'b1, {8'h58, 1'b0, 1'b0}, "flip_down");
        step(0, 0, 1, 1, 8'h00, 1'b1, {8'h59, 1'b0, 1'b0}, "flip_up");
        step(0, 0, 1, 1, 8'h00, 1'b1, {8'h60, 1'b0, 1'b0}, "carry_60");

        // random traffic
        for (int i = 0; i < 300; i++)
            run(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                8'($urandom_range(0, 255)), "random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
